seg7_scan_rx: RTL and testbench



---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_inv_lut.sv | 41 ++++
 rtl/seg7_scan_rx.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for seven-segment display decoding.
// Glyphs are active-low with segment a in bit 0 and segment g in bit 6.
// Contents: the sixteen hex glyph constants, the all-off blank pattern,
// and the packed decode-result struct returned by seg7_inv_lut.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // legal: pattern is one of the sixteen hex glyphs (nib valid)
    // blank: pattern is all segments off (legal is 0)
    // neither set: illegal pattern
    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nib;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_inv_lut.sv
// seg7_inv_lut: combinational inverse glyph map, active-low segments to nibble.
// Ports:
//   seg_n - 7-bit active-low segment pattern (bit 0 = a, bit 6 = g)
//   dec   - decode result {legal, blank, nib}; nib is 0 unless legal
module seg7_inv_lut
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output seg7_dec_t  dec
);

    always_comb begin
        dec.legal = 1'b1;
        dec.blank = 1'b0;
        dec.nib   = 4'h0;
        case (seg_n)
            SEG_0:     dec.nib = 4'h0;
            SEG_1:     dec.nib = 4'h1;
            SEG_2:     dec.nib = 4'h2;
            SEG_3:     dec.nib = 4'h3;
            SEG_4:     dec.nib = 4'h4;
            SEG_5:     dec.nib = 4'h5;
            SEG_6:     dec.nib = 4'h6;
            SEG_7:     dec.nib = 4'h7;
            SEG_8:     dec.nib = 4'h8;
            SEG_9:     dec.nib = 4'h9;
            SEG_A:     dec.nib = 4'hA;
            SEG_B:     dec.nib = 4'hB;
            SEG_C:     dec.nib = 4'hC;
            SEG_D:     dec.nib = 4'hD;
            SEG_E:     dec.nib = 4'hE;
            SEG_F:     dec.nib = 4'hF;
            SEG_BLANK: begin
                dec.legal = 1'b0;
                dec.blank = 1'b1;
            end
            default:   dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: receive side of a multiplexed seven-segment display.
// Samples the active-low segment bus and digit strobes, requires a pattern
// to hold for STABLE_CYCLES consecutive samples, then commits the decoded
// nibble (or blank/illegal status) to the strobed digit's register.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   seg_n        - active-low segment bus (bit 0 = a, bit 6 = g)
//   dig_en_n     - active-low digit strobes, one low per scan slot
//   value        - decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  - per-digit legal-glyph flag
//   update       - one-cycle pulse when any digit value/valid changes
//   err          - one-cycle pulse on illegal glyph commit or multi-hot entry
module seg7_scan_rx
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_en_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  err
);

    localparam int unsigned    SW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    // Strobe decode
    logic [3:0]          w_nlow;
    logic [SW-1:0]       w_sel;
    logic                w_one;
    logic                w_multi;

    // Previous sample; r_prev_vld = 0 encodes "no strobe"
    logic                r_prev_vld;
    logic [SW-1:0]       r_prev_sel;
    logic [6:0]          r_prev_seg;

    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_same;
    logic                w_commit;

    logic                r_multi;

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_valid;
    logic                r_update;
    logic                r_err;

    logic [4*DIGITS-1:0] w_value_nxt;
    logic [DIGITS-1:0]   w_valid_nxt;
    logic                w_upd;
    logic                w_ill;
    logic [3:0]          w_old_nib;
    logic                w_old_vld;

    seg7_dec_t           w_dec;

    seg7_inv_lut u_lut (
        .seg_n (seg_n),
        .dec   (w_dec)
    );

    always_comb begin
        w_nlow = '0;
        w_sel  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!dig_en_n[i]) begin
                w_nlow = w_nlow + 4'd1;
                w_sel  = SW'(i);
            end
        end
    end

    assign w_one   = (w_nlow == 4'd1);
    assign w_multi = (w_nlow > 4'd1);

    // A strobe change with an identical pattern is a different sample.
    assign w_same = r_prev_vld && (r_prev_sel == w_sel) && (r_prev_seg == seg_n);

    always_comb begin
        w_cnt_nxt = '0;
        if (w_one) begin
            if (!w_same)
                w_cnt_nxt = CW'(1);
            else if (r_cnt == CNT_MAX)
                w_cnt_nxt = r_cnt;
            else
                w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Commit only on the transition into CNT_MAX. With a single-cycle
    // dwell the load of 1 is itself the arrival, so a fresh sample commits.
    assign w_commit = w_one &&
                      (w_same ? (r_cnt == CNT_MAX - CW'(1)) : (STABLE_CYCLES == 1));

    assign w_old_nib = r_value[{w_sel, 2'b00} +: 4];
    assign w_old_vld = r_valid[w_sel];

    always_comb begin
        w_value_nxt = r_value;
        w_valid_nxt = r_valid;
        w_upd       = 1'b0;
        w_ill       = 1'b0;
        if (w_commit) begin
            if (w_dec.legal) begin
                w_value_nxt[{w_sel, 2'b00} +: 4] = w_dec.nib;
                w_valid_nxt[w_sel]               = 1'b1;
                w_upd = !w_old_vld || (w_old_nib != w_dec.nib);
            end else begin
                w_valid_nxt[w_sel] = 1'b0;
                w_upd = w_old_vld;
                w_ill = !w_dec.blank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_vld <= 1'b0;
            r_prev_sel <= '0;
            r_prev_seg <= SEG_BLANK;
            r_cnt      <= '0;
            r_multi    <= 1'b0;
            r_value    <= '0;
            r_valid    <= '0;
            r_update   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_prev_vld <= w_one;
            r_prev_sel <= w_one ? w_sel : '0;
            r_prev_seg <= w_one ? seg_n : SEG_BLANK;
            r_cnt      <= w_cnt_nxt;
            r_multi    <= w_multi;
            r_value    <= w_value_nxt;
            r_valid    <= w_valid_nxt;
            r_update   <= w_upd;
            r_err      <= w_ill || (w_multi && !r_multi);
        end
    end

    assign value       = r_value;
    assign digit_valid = r_valid;
    assign update      = r_update;
    assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb_seg7_scan_rx: directed self-checking bench for seg7_scan_rx
// (DIGITS=8, STABLE_CYCLES=4). Inputs change 1 time unit after each rising
// edge; outputs are sampled at the same point.
module tb_seg7_scan_rx;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_n;
    logic [7:0]  dig_en_n;
    logic [31:0] value;
    logic [7:0]  digit_valid;
    logic        update;
    logic        err;

    int n_cmp;
    int n_bad;
    int upd_cnt;
    int err_cnt;

    logic [6:0] glyph [8];

    seg7_scan_rx #(
        .DIGITS        (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_en_n    (dig_en_n),
        .value       (value),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        upd_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            upd_cnt += int'(update);
            err_cnt += int'(err);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;

        // Reset
        rst      = 1'b1;
        seg_n    = 7'h7F;
        dig_en_n = 8'hFF;
        clr_cnt();
        hold(3);
        chk("rst_value", 64'(value), 64'h0);
        chk("rst_valid", 64'(digit_valid), 64'h0);
        chk("rst_update", 64'(update), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        rst = 1'b0;
        hold(2);

        // Digit 2 shows "2": commit after the 4th edge, then silence
        dig_en_n = 8'hFB;
        seg_n    = 7'h24;
        clr_cnt();
        hold(3);
        chk("d2_early_valid", 64'(digit_valid), 64'h00);
        hold(1);
        chk("d2_update_now", 64'(update), 64'h1);
        chk("d2_value", 64'(value[11:8]), 64'h2);
        chk("d2_valid", 64'(digit_valid), 64'h04);
        hold(10);
        chk("d2_upd_count", 64'(upd_cnt), 64'd1);
        chk("d2_err_count", 64'(err_cnt), 64'd0);

        // Digit 0: short "0" dwell discarded, "1" commits
        dig_en_n = 8'hFE;
        seg_n    = 7'h40;
        clr_cnt();
        hold(3);
        chk("d0_short_valid", 64'(digit_valid[0]), 64'h0);
        seg_n = 7'h79;
        hold(4);
        chk("d0_value", 64'(value[3:0]), 64'h1);
        chk("d0_valid", 64'(digit_valid[0]), 64'h1);
        chk("d0_upd_count", 64'(upd_cnt), 64'd1);

        // Digit 5: "E" then blank
        dig_en_n = 8'hDF;
        seg_n    = 7'h06;
        hold(4);
        chk("d5_value_E", 64'(value[23:20]), 64'hE);
        chk("d5_valid_E", 64'(digit_valid[5]), 64'h1);
        seg_n = 7'h7F;
        clr_cnt();
        hold(4);
        chk("d5_blank_valid", 64'(digit_valid[5]), 64'h0);
        chk("d5_blank_value", 64'(value[23:20]), 64'hE);
        chk("d5_blank_upd", 64'(upd_cnt), 64'd1);
        chk("d5_blank_err", 64'(err_cnt), 64'd0);

        // Digit 1: "3" then illegal 55
        dig_en_n = 8'hFD;
        seg_n    = 7'h30;
        hold(4);
        chk("d1_value_3", 64'(value[7:4]), 64'h3);
        seg_n = 7'h55;
        clr_cnt();
        hold(3);
        chk("d1_ill_early", 64'({update, err}), 64'h0);
        hold(1);
        chk("d1_ill_pulses", 64'({update, err}), 64'h3);
        chk("d1_ill_valid", 64'(digit_valid[1]), 64'h0);
        chk("d1_ill_value", 64'(value[7:4]), 64'h3);

        // Multi-hot strobes for 6 cycles: single err, no digit change
        dig_en_n = 8'hFC;
        seg_n    = 7'h00;
        clr_cnt();
        hold(6);
        chk("mh_err_count", 64'(err_cnt), 64'd1);
        chk("mh_upd_count", 64'(upd_cnt), 64'd0);
        chk("mh_value", 64'(value), 64'h00E0_0231);
        chk("mh_valid", 64'(digit_valid), 64'h05);

        // Full scan 0..7 with blanking gaps; digit 2 already holds 2
        clr_cnt();
        for (int d = 0; d < 8; d++) begin
            dig_en_n = ~(8'h01 << d);
            seg_n    = glyph[d];
            hold(4);
            dig_en_n = 8'hFF;
            hold(2);
        end
        chk("scan_value", 64'(value), 64'h7654_3210);
        chk("scan_valid", 64'(digit_valid), 64'hFF);
        chk("scan_upd_count", 64'(upd_cnt), 64'd7);
        chk("scan_err_count", 64'(err_cnt), 64'd0);

        // Reset two cycles into an "E" dwell on digit 3
        dig_en_n = 8'hF7;
        seg_n    = 7'h06;
        hold(2);
        rst = 1'b1;
        hold(1);
        chk("mid_rst_value", 64'(value), 64'h0);
        chk("mid_rst_valid", 64'(digit_valid), 64'h0);
        rst = 1'b0;
        clr_cnt();
        hold(3);
        chk("post_rst_early", 64'(digit_valid), 64'h00);
        chk("post_rst_early_upd", 64'(upd_cnt), 64'd0);
        hold(1);
        chk("post_rst_update", 64'(update), 64'h1);
        chk("post_rst_value", 64'(value[15:12]), 64'hE);
        chk("post_rst_valid", 64'(digit_valid), 64'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
